// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte interface between two producers.
// Requester 0 is the CPU register path, requester 1 the monitor/debug path.
// Each has a DEPTH-entry FIFO. A two-state scheduler pops FIFO heads into a
// registered valid/ready output using round-robin arbitration. When LINE_LOCK
// is set, an owner keeps the grant until it sends 0x0A or its FIFO stays empty
// for LOCK_TIMEOUT idle cycles, so text lines from the two sources never mix.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_data/reqN_wr           byte write into requester N FIFO
//   reqN_full/reqN_empty        requester N FIFO status
//   tx_data/tx_data_valid       byte offered to uart_tx (held until ready)
//   tx_data_ready               uart_tx accepts the byte
//   grant                       one-hot owner of the byte in flight, 00 if none
//   req_ovf/ovf_clr             sticky per-requester overflow flags and clear
module uart_tx_arbiter #(
  parameter int unsigned DEPTH        = 8,
  parameter bit          LINE_LOCK    = 1'b1,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_wr,
  output logic       req0_full,
  output logic       req0_empty,
  input  logic [7:0] req1_data,
  input  logic       req1_wr,
  output logic       req1_full,
  output logic       req1_empty,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ready,
  output logic [1:0] grant,
  output logic [1:0] req_ovf,
  input  logic       ovf_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // FIFO storage and bookkeeping, index 0/1 = requester 0/1.
  logic [7:0]    mem_q  [2][DEPTH];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [7:0]    wdata  [2];

  logic [1:0] wr, full, empty, push, pop, ovf_set;
  logic [1:0] req_ovf_q;

  // Scheduler state.
  state_e        state_q;
  logic [7:0]    tx_data_q;
  logic          valid_q;
  logic [1:0]    grant_q;
  logic          last_owner_q;
  logic          lock_q;
  logic          lock_owner_q;
  logic [TW-1:0] to_cnt_q;

  logic [1:0] elig;
  logic       sel;
  logic       pick;
  logic       owner_empty;
  logic [7:0] head;

  always_comb begin
    wr       = {req1_wr, req0_wr};
    wdata[0] = req0_data;
    wdata[1] = req1_data;
    for (int i = 0; i < 2; i++) begin
      full[i]    = (cnt_q[i] == CW'(DEPTH));
      empty[i]   = (cnt_q[i] == '0);
      // Full is judged on the start-of-cycle count; a same-cycle pop does not help.
      push[i]    = wr[i] && !full[i];
      ovf_set[i] = wr[i] && full[i];
    end
  end

  // Arbitration: a held lock masks the non-owner; on a tie the requester that
  // did not send last wins.
  always_comb begin
    elig = ~empty;
    if (lock_q) begin
      elig = elig & (lock_owner_q ? 2'b10 : 2'b01);
    end
    sel         = (elig == 2'b11) ? ~last_owner_q : elig[1];
    pick        = (state_q == StIdle) && (elig != 2'b00);
    pop         = pick ? (sel ? 2'b10 : 2'b01) : 2'b00;
    head        = mem_q[sel][rptr_q[sel]];
    owner_empty = lock_owner_q ? empty[1] : empty[0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= wdata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      req_ovf_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      // Set wins over a simultaneous clear.
      req_ovf_q <= (ovf_clr ? 2'b00 : req_ovf_q) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tx_data_q    <= 8'h00;
      valid_q      <= 1'b0;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick) begin
            tx_data_q    <= head;
            valid_q      <= 1'b1;
            grant_q      <= sel ? 2'b10 : 2'b01;
            last_owner_q <= sel;
            state_q      <= StSend;
          end
          // Lock timeout: count idle cycles while the owner has nothing queued.
          if (lock_q && owner_empty) begin
            if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
              lock_q   <= 1'b0;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end else begin
            to_cnt_q <= '0;
          end
        end
        StSend: begin
          to_cnt_q <= '0;
          if (tx_data_ready) begin
            valid_q <= 1'b0;
            grant_q <= 2'b00;
            state_q <= StIdle;
            if (LINE_LOCK) begin
              // A newline ends the line and releases the lock; anything else claims it.
              lock_q       <= (tx_data_q != 8'h0A);
              lock_owner_q <= grant_q[1];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_full     = full[0];
  assign req0_empty    = empty[0];
  assign req1_full     = full[1];
  assign req1_empty    = empty[1];
  assign tx_data       = tx_data_q;
  assign tx_data_valid = valid_q;
  assign grant         = grant_q;
  assign req_ovf       = req_ovf_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Two instances: index 0 has LINE_LOCK=0, index 1
// has LINE_LOCK=1 with LOCK_TIMEOUT=16. Every accepted byte is pushed to a
// per-instance expectation queue; a negedge monitor pops on each handshake.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s [2];
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic       wr0 [2];
  logic       wr1 [2];
  logic       ready [2];
  logic       clr [2];
  logic       full0 [2];
  logic       empty0 [2];
  logic       full1 [2];
  logic       empty1 [2];
  logic       valid [2];
  logic [7:0] txd [2];
  logic [1:0] grant [2];
  logic [1:0] ovf [2];

  int n_vec  = 0;
  int n_miss = 0;

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  uart_tx_arbiter #(.DEPTH(8), .LINE_LOCK(1'b0), .LOCK_TIMEOUT(1024)) u_dut0 (
    .clk(clk), .rst_n(rst_n_s[0]),
    .req0_data(d0[0]), .req0_wr(wr0[0]), .req0_full(full0[0]), .req0_empty(empty0[0]),
    .req1_data(d1[0]), .req1_wr(wr1[0]), .req1_full(full1[0]), .req1_empty(empty1[0]),
    .tx_data(txd[0]), .tx_data_valid(valid[0]), .tx_data_ready(ready[0]),
    .grant(grant[0]), .req_ovf(ovf[0]), .ovf_clr(clr[0])
  );

  uart_tx_arbiter #(.DEPTH(8), .LINE_LOCK(1'b1), .LOCK_TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n_s[1]),
    .req0_data(d0[1]), .req0_wr(wr0[1]), .req0_full(full0[1]), .req0_empty(empty0[1]),
    .req1_data(d1[1]), .req1_wr(wr1[1]), .req1_full(full1[1]), .req1_empty(empty1[1]),
    .tx_data(txd[1]), .tx_data_valid(valid[1]), .tx_data_ready(ready[1]),
    .grant(grant[1]), .req_ovf(ovf[1]), .ovf_clr(clr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int k, input logic [1:0] g, input logic [7:0] d);
    if (k == 0) q0.push_back({g, d});
    else        q1.push_back({g, d});
  endtask

  task automatic do_reset(input int k);
    rst_n_s[k] = 1'b0;
    d0[k] = 8'h00; d1[k] = 8'h00; wr0[k] = 1'b0; wr1[k] = 1'b0;
    ready[k] = 1'b0; clr[k] = 1'b0;
    if (k == 0) q0.delete();
    else        q1.delete();
    tick();
    tick();
    rst_n_s[k] = 1'b1;
    tick();
  endtask

  task automatic drain(input int k, input int budget);
    int left;
    left = (k == 0) ? q0.size() : q1.size();
    for (int i = 0; i < budget && left != 0; i++) begin
      tick();
      left = (k == 0) ? q0.size() : q1.size();
    end
    check($sformatf("dut%0d drain leftover", k), left, 0);
  endtask

  // Scoreboard monitors: one handshake per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n_s[0] && valid[0] && ready[0]) begin
      if (q0.size() == 0) check("dut0 unexpected byte", q0.size(), 1);
      else                check("dut0 tx byte {grant,data}", {grant[0], txd[0]}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n_s[1] && valid[1] && ready[1]) begin
      if (q1.size() == 0) check("dut1 unexpected byte", q1.size(), 1);
      else                check("dut1 tx byte {grant,data}", {grant[1], txd[1]}, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n_s[k] = 1'b0; d0[k] = 8'h00; d1[k] = 8'h00; wr0[k] = 1'b0; wr1[k] = 1'b0;
      ready[k] = 1'b0; clr[k] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    // Reset state.
    check("reset req0_empty", empty0[0], 1);
    check("reset req1_empty", empty1[0], 1);
    check("reset req0_full", full0[0], 0);
    check("reset tx_data", txd[0], 8'h00);
    check("reset valid", valid[0], 0);
    check("reset grant", grant[0], 2'b00);
    check("reset req_ovf", ovf[0], 2'b00);
    check("reset dut1 valid", valid[1], 0);

    // Single byte latency: write in N, valid in N+2, gone in N+3.
    ready[0] = 1'b1;
    d0[0] = 8'h41; wr0[0] = 1'b1; exp_push(0, 2'b01, 8'h41);
    tick();
    wr0[0] = 1'b0;
    check("t1 valid N+1", valid[0], 0);
    tick();
    check("t1 valid N+2", valid[0], 1);
    check("t1 data N+2", txd[0], 8'h41);
    check("t1 grant N+2", grant[0], 2'b01);
    tick();
    check("t1 valid N+3", valid[0], 0);
    check("t1 grant N+3", grant[0], 2'b00);
    check("t1 req0_empty N+3", empty0[0], 1);
    check("t1 data held N+3", txd[0], 8'h41);

    // Per-byte round robin (LINE_LOCK=0).
    do_reset(0);
    d0[0] = 8'h30; d1[0] = 8'h50; wr0[0] = 1'b1; wr1[0] = 1'b1;
    tick();
    d0[0] = 8'h31; d1[0] = 8'h51;
    tick();
    wr0[0] = 1'b0; wr1[0] = 1'b0;
    exp_push(0, 2'b01, 8'h30); exp_push(0, 2'b10, 8'h50);
    exp_push(0, 2'b01, 8'h31); exp_push(0, 2'b10, 8'h51);
    ready[0] = 1'b1;
    drain(0, 40);

    // Line lock keeps requester 0 through "AB\n".
    do_reset(1);
    d0[1] = 8'h41; d1[1] = 8'h58; wr0[1] = 1'b1; wr1[1] = 1'b1;
    tick();
    wr1[1] = 1'b0; d0[1] = 8'h42;
    tick();
    d0[1] = 8'h0A;
    tick();
    wr0[1] = 1'b0;
    exp_push(1, 2'b01, 8'h41); exp_push(1, 2'b01, 8'h42);
    exp_push(1, 2'b01, 8'h0A); exp_push(1, 2'b10, 8'h58);
    ready[1] = 1'b1;
    drain(1, 40);

    // Lock timeout: 0x58 waits exactly 16 empty-owner idle cycles.
    do_reset(1);
    ready[1] = 1'b1;
    d0[1] = 8'h41; d1[1] = 8'h58; wr0[1] = 1'b1; wr1[1] = 1'b1;
    exp_push(1, 2'b01, 8'h41); exp_push(1, 2'b10, 8'h58);
    tick();
    wr0[1] = 1'b0; wr1[1] = 1'b0;
    tick();
    check("t4 valid N+2", valid[1], 1);
    check("t4 data N+2", txd[1], 8'h41);
    for (int i = 3; i <= 19; i++) begin
      tick();
      check($sformatf("t4 valid low N+%0d", i), valid[1], 0);
    end
    tick();
    check("t4 valid N+20", valid[1], 1);
    check("t4 data N+20", txd[1], 8'h58);
    check("t4 grant N+20", grant[1], 2'b10);
    drain(1, 10);

    // Overflow with tx stalled: first byte sits in tx_data, 8 fill the FIFO.
    do_reset(0);
    wr1[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d1[0] = 8'hA0 + 8'(i);
      if (i < 9) exp_push(0, 2'b10, 8'hA0 + 8'(i));
      if (i == 5) check("t5 tx_data stable", txd[0], 8'hA0);
      if (i == 8) check("t5 req1_full before 8th", full1[0], 0);
      if (i == 9) begin
        check("t5 req1_full", full1[0], 1);
        check("t5 ovf before drop", ovf[0], 2'b00);
      end
      tick();
    end
    check("t5 req_ovf", ovf[0], 2'b10);
    check("t5 tx_data held", txd[0], 8'hA0);
    check("t5 valid held", valid[0], 1);
    check("t5 grant held", grant[0], 2'b10);
    d1[0] = 8'hAA; clr[0] = 1'b1;
    tick();
    wr1[0] = 1'b0; clr[0] = 1'b0;
    check("t5 ovf set beats clr", ovf[0], 2'b10);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("t5 ovf cleared", ovf[0], 2'b00);
    ready[0] = 1'b1;
    drain(0, 60);

    // Asynchronous reset mid-SEND.
    do_reset(0);
    d0[0] = 8'h77; wr0[0] = 1'b1;
    tick();
    wr0[0] = 1'b0;
    tick();
    check("t6 valid before reset", valid[0], 1);
    #2;
    rst_n_s[0] = 1'b0;
    #1;
    check("t6 async valid", valid[0], 0);
    check("t6 async grant", grant[0], 2'b00);
    check("t6 async req0_empty", empty0[0], 1);
    check("t6 async req1_empty", empty1[0], 1);
    check("t6 async tx_data", txd[0], 8'h00);
    tick();
    tick();
    rst_n_s[0] = 1'b1;
    tick();
    ready[0] = 1'b1;
    d0[0] = 8'h55; wr0[0] = 1'b1; exp_push(0, 2'b01, 8'h55);
    tick();
    wr0[0] = 1'b0;
    drain(0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between two byte producers: requester 0 is the CPU register path and requester 1 is the monitor/debug path. Each requester has its own small FIFO. A scheduler drains the FIFOs into the transmitter's valid/ready handshake using round-robin arbitration, with optional line locking so text lines from the two sources never interleave. The block sits between the CPU-side register logic and the uart_tx instance.

Parameters:
DEPTH, 8, entries per requester FIFO; power of two, minimum 2.
LINE_LOCK, 1, 1 = an owner keeps the grant until it sends 0x0A or times out; 0 = pure per-byte round-robin.
LOCK_TIMEOUT, 1024, consecutive idle cycles with the locked owner's FIFO empty before the lock is dropped.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req0_data  in  8  requester 0 write byte
req0_wr  in  1  requester 0 write strobe, one byte per cycle
req0_full  out  1  requester 0 FIFO holds DEPTH entries
req0_empty  out  1  requester 0 FIFO holds 0 entries
req1_data  in  8  requester 1 write byte
req1_wr  in  1  requester 1 write strobe
req1_full  out  1  requester 1 FIFO full
req1_empty  out  1  requester 1 FIFO empty
tx_data  out  8  byte to uart_tx
tx_data_valid  out  1  byte valid to uart_tx
tx_data_ready  in  1  uart_tx accepts the byte
grant  out  2  one-hot owner of the byte in flight; 00 when none
req_ovf  out  2  sticky overflow flag per requester
ovf_clr  in  1  clears both req_ovf bits

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values, applied whenever rst_n is low including mid-transfer:
  - FIFOs emptied; reqN_empty=1, reqN_full=0.
  - tx_data=0x00, tx_data_valid=0, grant=00, req_ovf=00.
  - Lock cleared; last_owner=1, so requester 0 wins the first tie.
- FIFO write rules:
  - reqN_wr with full=0 stores the byte; it is visible as non-empty on the next cycle.
  - reqN_wr with full=1 drops the byte and sets req_ovf[N], even if a pop happens the same cycle. Full is evaluated at the start of the cycle.
- Overflow flag: ovf_clr clears both req_ovf bits. If an overflow and ovf_clr occur in the same cycle, set wins for that bit.
- FSM states: IDLE, SEND.
- IDLE:
  - Eligible requesters are those with non-empty FIFOs.
  - If a lock is held, only the locked owner is eligible.
  - If both are eligible, pick the one that is not last_owner; otherwise pick the single eligible one.
  - On selection, in the same edge: pop the head into tx_data, set tx_data_valid=1, set grant, set last_owner, go to SEND.
  - If nothing is eligible, stay in IDLE.
- SEND:
  - tx_data, tx_data_valid and grant are held stable until tx_data_ready=1.
  - On the handshake edge: tx_data_valid=0, grant=00, return to IDLE. tx_data keeps its last value.
- Latency:
  - A write in cycle N into an empty, unlocked-out block gives tx_data_valid=1 in cycle N+2.
  - After a handshake in cycle M, the next valid rises no earlier than M+2 (one IDLE bubble).
- Line lock (LINE_LOCK=1):
  - Sending a byte other than 0x0A sets lock=owner.
  - Sending 0x0A clears the lock at the handshake.
  - In IDLE with a lock held and the owner's FIFO empty, a counter increments. When it reaches LOCK_TIMEOUT, the lock clears and the counter zeroes.
  - The counter zeroes whenever the owner's FIFO is non-empty or no lock is held.
- With LINE_LOCK=0: no lock is ever set and the counter is unused.
- Writes to a FIFO continue to be accepted while the other requester holds the lock.
- Width rules: FIFO occupancy counters are $clog2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.

Test Plan:
- Reset, then req0 writes 0x41 in cycle N with tx_data_ready=1 -> tx_data_valid=1, tx_data=0x41, grant=01 in cycle N+2; valid=0 and grant=00 in N+3; req0_empty=1.
- LINE_LOCK=0, both FIFOs preloaded with 0x30,0x31 / 0x50,0x51, ready always 1 -> output order 0x30,0x50,0x31,0x51, grant alternating 01,10,01,10.
- LINE_LOCK=1, req0 holds "AB\n" (0x41,0x42,0x0A) and req1 holds 0x58 -> output 0x41,0x42,0x0A,0x58; grant stays 01 for the first three bytes.
- LINE_LOCK=1, LOCK_TIMEOUT=16, req0 sends 0x41 only and req1 holds 0x58 -> 0x58 is issued exactly after 16 empty-owner IDLE cycles, not earlier.
- DEPTH=8, tx_data_ready=0, req1 writes 10 bytes -> 8 stored then req1_full=1; req_ovf=10; tx_data stable while valid held. ovf_clr pulsed together with an 11th write -> req_ovf stays 10; ovf_clr alone -> 00.
- rst_n pulsed low mid-SEND with ready=0 -> asynchronously tx_data_valid=0, grant=00, both empty=1; after release, a new req0 write 0x55 is sent normally.
